as_layer_ctrl: RTL
==================

Name: as_layer_ctrl

Overview:
- Layer-level controller for the upsample/route address sequencer.
- Accepts one layer command per valid/ready handshake and latches it.
- Derives the sequencer configuration (dims, channels, row stride, route offset, mode), then issues one start pulse per pass.
- Waits for the sequencer's done pulse; route layers with two sources run two back-to-back passes. Sits between the top-level layer scheduler and the address sequencer.

Parameters:
W_SIZE, 9, width of width/height fields
W_CHANNEL, 11, width of channel fields
FM_AW, 16, feature-map buffer address width (route offset)
WDT_CYCLES, 65535, watchdog limit in cycles (used only with AS_WDT_EN)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
cmd_vld  in  1  command valid
cmd_rdy  out  1  controller ready; high only in IDLE
cmd_mode  in  1  0=upsample, 1=route
cmd_two_src  in  1  route: 1=two sources (ignored for upsample)
cmd_width  in  W_SIZE  input width
cmd_height  in  W_SIZE  input height
cmd_ch0  in  W_CHANNEL  upsample channels / route source-0 channels
cmd_ch1  in  W_CHANNEL  route source-1 channels
q_width  out  W_SIZE  sequencer width
q_height  out  W_SIZE  sequencer height
q_channel  out  W_CHANNEL  channels of current pass
q_channel_out  out  W_CHANNEL  output pixel channel count
q_row_stride  out  W_SIZE+W_CHANNEL  q_width*q_channel
q_as_mode  out  1  sequencer mode
q_route_offset  out  FM_AW  channel offset of current pass
q_addr_seq_start  out  1  one-cycle start pulse
addr_seq_done  in  1  sequencer done pulse
busy  out  1  high when not IDLE
layer_done  out  1  one-cycle pulse at end of layer

Behaviour:
- Reset: async, rstn=0 clears all state; FSM=IDLE. All outputs are 0 except cmd_rdy=1. Reset mid-layer aborts silently: no layer_done.
- FSM states: IDLE, CFG, START, WAIT, DONE.
- IDLE:
  - cmd_rdy=1.
  - On cmd_vld&cmd_rdy, latch all cmd fields, clear pass index p=0, go to CFG.
- CFG (1 cycle), registers the q_* outputs:
  - Common: q_width=cmd_width, q_height=cmd_height, q_as_mode=cmd_mode.
  - Upsample: q_channel=q_channel_out=ch0, offset 0.
  - Route p=0: q_channel=ch0, offset=0, q_channel_out = two_src ? ch0+ch1 : ch0.
  - Route p=1: q_channel=ch1, offset=ch0 (zero-extended to FM_AW).
  - q_row_stride = width*q_channel, full-precision product truncated to W_SIZE+W_CHANNEL. It is stable from START onward.
  - ch0+ch1 wraps mod 2^W_CHANNEL; no saturation.
- START: q_addr_seq_start=1 for exactly one cycle, then WAIT.
- WAIT:
  - Hold all q_* stable.
  - On addr_seq_done: if route & two_src & p==0, set p=1 and go to CFG; else go to DONE.
  - addr_seq_done outside WAIT is ignored.
  - addr_seq_done coincident with the START cycle is ignored; the controller keeps waiting.
- DONE: layer_done=1 for one cycle, then IDLE.
- Latency, with cmd accepted at cycle T:
  - Start pulse at T+2.
  - Done at Td gives layer_done at Td+1 and cmd_rdy at Td+2.
  - For a two-pass layer, the second start is at Td+2.
- q_* outputs retain their last values in IDLE.
- busy = (state != IDLE).

Optional Feature:
- Macro AS_WDT_EN.
- Defined:
  - Adds output port wdt_err (1 bit) and a cycle counter.
  - The counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches WDT_CYCLES-1 without done, the FSM goes to DONE. layer_done and wdt_err pulse together; the remaining pass is skipped.
  - A sticky internal flag is cleared on the next command accept.
- Undefined: no port, no counter; WAIT waits indefinitely.

Test Plan:
- Upsample cmd (mode=0, w=13, h=13, ch0=256); done at start+5 -> one start pulse at T+2; q_channel=q_channel_out=256, q_row_stride=3328, offset=0; layer_done one cycle after done.
- Route two-src (w=26, h=26, ch0=128, ch1=256) -> pass0: q_channel=128, offset=0, stride=3328, q_channel_out=384. Pass1 start 2 cycles after first done: q_channel=256, offset=128, stride=6656. Exactly one layer_done.
- Route single-src (two_src=0, ch0=64) -> one pass, q_channel_out=64, one layer_done.
- Spurious addr_seq_done in IDLE and on the START cycle, plus cmd_vld held high during busy -> no state change, cmd_rdy=0 while busy, next cmd accepted only after IDLE.
- rstn asserted during WAIT of pass0 -> outputs zero immediately, cmd_rdy=1, no layer_done; a new command then runs normally.
- AS_WDT_EN with WDT_CYCLES=16, no done returned -> wdt_err and layer_done pulse after 16 WAIT cycles; route pass1 is not started.

Source files
------------

// File: rtl/as_layer_ctrl.sv
// Layer-level controller for the upsample/route address sequencer: latches a layer
// command, programs the sequencer per pass and pulses start/done. Optional AS_WDT_EN adds a WAIT watchdog.
module as_layer_ctrl #(
  parameter int W_SIZE    = 9,
  parameter int W_CHANNEL = 11,
  parameter int FM_AW     = 16
`ifdef AS_WDT_EN
  , parameter int WDT_CYCLES = 65535
`endif
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          cmd_vld,
  output logic                          cmd_rdy,
  input  logic                          cmd_mode,
  input  logic                          cmd_two_src,
  input  logic [W_SIZE-1:0]             cmd_width,
  input  logic [W_SIZE-1:0]             cmd_height,
  input  logic [W_CHANNEL-1:0]          cmd_ch0,
  input  logic [W_CHANNEL-1:0]          cmd_ch1,
  output logic [W_SIZE-1:0]             q_width,
  output logic [W_SIZE-1:0]             q_height,
  output logic [W_CHANNEL-1:0]          q_channel,
  output logic [W_CHANNEL-1:0]          q_channel_out,
  output logic [W_SIZE+W_CHANNEL-1:0]   q_row_stride,
  output logic                          q_as_mode,
  output logic [FM_AW-1:0]              q_route_offset,
  output logic                          q_addr_seq_start,
  input  logic                          addr_seq_done,
  output logic                          busy,
  output logic                          layer_done
`ifdef AS_WDT_EN
  , output logic                        wdt_err
`endif
);

  localparam int SW = W_SIZE + W_CHANNEL;

  typedef enum logic [2:0] {IDLE, CFG, START, WAIT, DONE} state_t;
  state_t state, state_nxt;

  logic                 l_mode, l_two_src, pass;
  logic [W_SIZE-1:0]    l_width, l_height;
  logic [W_CHANNEL-1:0] l_ch0, l_ch1;
  logic                 accept, second_pass, wdt_hit;

  assign accept      = cmd_vld & cmd_rdy;
  assign second_pass = l_mode & l_two_src & ~pass;

`ifdef AS_WDT_EN
  localparam int CW = (WDT_CYCLES > 2) ? $clog2(WDT_CYCLES) : 1;
  logic [CW-1:0] wdt_cnt;
  logic          wdt_flag;

  assign wdt_hit = (wdt_cnt == CW'(WDT_CYCLES - 1));
  assign wdt_err = (state == DONE) & wdt_flag;

  // Counter restarts on every START so each pass gets a full budget.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wdt_cnt  <= '0;
      wdt_flag <= 1'b0;
    end else begin
      if (state == START)     wdt_cnt <= '0;
      else if (state == WAIT) wdt_cnt <= wdt_cnt + 1'b1;
      if (accept)
        wdt_flag <= 1'b0;
      else if (state == WAIT && !addr_seq_done && wdt_hit)
        wdt_flag <= 1'b1;
    end
  end
`else
  assign wdt_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = CFG;
      CFG:   state_nxt = START;
      START: state_nxt = WAIT;  // a done seen here belongs to nothing we issued
      WAIT: begin
        if (addr_seq_done) state_nxt = second_pass ? CFG : DONE;
        else if (wdt_hit)  state_nxt = DONE;
      end
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign cmd_rdy          = (state == IDLE);
  assign busy             = (state != IDLE);
  assign q_addr_seq_start = (state == START);
  assign layer_done       = (state == DONE);

  // Command latch and pass index
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      l_mode    <= 1'b0;
      l_two_src <= 1'b0;
      l_width   <= '0;
      l_height  <= '0;
      l_ch0     <= '0;
      l_ch1     <= '0;
      pass      <= 1'b0;
    end else if (accept) begin
      l_mode    <= cmd_mode;
      l_two_src <= cmd_two_src;
      l_width   <= cmd_width;
      l_height  <= cmd_height;
      l_ch0     <= cmd_ch0;
      l_ch1     <= cmd_ch1;
      pass      <= 1'b0;
    end else if (state == WAIT && addr_seq_done && second_pass) begin
      pass      <= 1'b1;
    end
  end

  // Per-pass configuration, computed from the latched command
  logic [W_CHANNEL-1:0] ch_nxt, ch_out_nxt;
  logic [FM_AW-1:0]     off_nxt;
  logic [SW-1:0]        stride_nxt;

  always_comb begin
    ch_nxt     = l_ch0;
    ch_out_nxt = l_ch0;
    off_nxt    = '0;
    if (l_mode) begin
      if (pass) begin
        ch_nxt     = l_ch1;
        ch_out_nxt = q_channel_out;
        off_nxt    = FM_AW'(l_ch0);
      end else if (l_two_src) begin
        ch_out_nxt = l_ch0 + l_ch1;  // wraps by design
      end
    end
    stride_nxt = SW'(l_width) * SW'(ch_nxt);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q_width        <= '0;
      q_height       <= '0;
      q_channel      <= '0;
      q_channel_out  <= '0;
      q_row_stride   <= '0;
      q_as_mode      <= 1'b0;
      q_route_offset <= '0;
    end else if (state == CFG) begin
      q_width        <= l_width;
      q_height       <= l_height;
      q_channel      <= ch_nxt;
      q_channel_out  <= ch_out_nxt;
      q_row_stride   <= stride_nxt;
      q_as_mode      <= l_mode;
      q_route_offset <= off_nxt;
    end
  end

endmodule
